// File: rtl/note_segmenter_if.sv
// Frame-side inputs and FIFO-side handshake of the note segmenter.
interface note_segmenter_if #(
  parameter int unsigned NOTE_W = 8,
  parameter int unsigned DUR_W  = 16
);
  logic [NOTE_W-1:0] note_in;
  logic              note_dec;
  logic              flush;
  logic [NOTE_W-1:0] note_out;
  logic [DUR_W-1:0]  duration;
  logic              out_valid;
  logic              out_ready;
  logic              drop_err;
  logic              busy;

  modport master (
    output note_in, note_dec, flush, out_ready,
    input  note_out, duration, out_valid, drop_err, busy
  );

  modport slave (
    input  note_in, note_dec, flush, out_ready,
    output note_out, duration, out_valid, drop_err, busy
  );
endinterface

// File: rtl/note_segmenter.sv
// Groups per-frame note codes into (note, duration) segments with glitch rejection,
// optional rest suppression and a small output FIFO.
module note_segmenter #(
  parameter int unsigned NOTE_W     = 8,
  parameter int unsigned DUR_W      = 16,
  parameter int unsigned MIN_FRAMES = 2,
  parameter int unsigned REST_CODE  = 0,
  parameter bit          DROP_RESTS = 1'b0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  note_segmenter_if.slave  bus_io
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StTrack, StCand} state_e;

  state_e            state_q, state_d;
  logic [NOTE_W-1:0] cur_note_q, cur_note_d, cand_note_q, cand_note_d;
  logic [DUR_W-1:0]  cur_cnt_q, cur_cnt_d, cand_cnt_q, cand_cnt_d;

  logic              emit;
  logic [NOTE_W-1:0] emit_note;
  logic [DUR_W-1:0]  emit_dur;

  logic [NOTE_W-1:0] mem_note_q [FIFO_DEPTH];
  logic [DUR_W-1:0]  mem_dur_q  [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic [NOTE_W-1:0] last_note_q;
  logic [DUR_W-1:0]  last_dur_q;
  logic              drop_q;
  logic              out_valid, full, pop, push_req, push_ok;

  function automatic logic [DUR_W-1:0] sat_add(input logic [DUR_W-1:0] a,
                                                input logic [DUR_W-1:0] b);
    logic [DUR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DUR_W] ? '1 : s[DUR_W-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    cur_note_d  = cur_note_q;
    cur_cnt_d   = cur_cnt_q;
    cand_note_d = cand_note_q;
    cand_cnt_d  = cand_cnt_q;
    emit        = 1'b0;
    emit_note   = cur_note_q;
    emit_dur    = cur_cnt_q;
    if (bus_io.flush) begin
      // Flush wins over a same-cycle strobe; pending candidate frames go to the current note.
      if (state_q != StIdle) begin
        emit       = 1'b1;
        emit_dur   = (state_q == StCand) ? sat_add(cur_cnt_q, cand_cnt_q) : cur_cnt_q;
        state_d    = StIdle;
        cur_cnt_d  = '0;
        cand_cnt_d = '0;
      end
    end else if (bus_io.note_dec) begin
      unique case (state_q)
        StIdle: begin
          cur_note_d = bus_io.note_in;
          cur_cnt_d  = DUR_W'(1);
          state_d    = StTrack;
        end
        StTrack: begin
          if (bus_io.note_in == cur_note_q) begin
            cur_cnt_d = sat_add(cur_cnt_q, DUR_W'(1));
          end else if (MIN_FRAMES == 1) begin
            emit       = 1'b1;
            cur_note_d = bus_io.note_in;
            cur_cnt_d  = DUR_W'(1);
          end else begin
            cand_note_d = bus_io.note_in;
            cand_cnt_d  = DUR_W'(1);
            state_d     = StCand;
          end
        end
        StCand: begin
          if (bus_io.note_in == cand_note_q) begin
            if (cand_cnt_q + DUR_W'(1) == DUR_W'(MIN_FRAMES)) begin
              emit       = 1'b1;
              cur_note_d = cand_note_q;
              cur_cnt_d  = DUR_W'(MIN_FRAMES);
              cand_cnt_d = '0;
              state_d    = StTrack;
            end else begin
              cand_cnt_d = cand_cnt_q + DUR_W'(1);
            end
          end else if (bus_io.note_in == cur_note_q) begin
            cur_cnt_d  = sat_add(cur_cnt_q, cand_cnt_q + DUR_W'(1));
            cand_cnt_d = '0;
            state_d    = StTrack;
          end else begin
            cur_cnt_d   = sat_add(cur_cnt_q, cand_cnt_q);
            cand_note_d = bus_io.note_in;
            cand_cnt_d  = DUR_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cur_note_q  <= '0;
      cur_cnt_q   <= '0;
      cand_note_q <= '0;
      cand_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_note_q  <= cur_note_d;
      cur_cnt_q   <= cur_cnt_d;
      cand_note_q <= cand_note_d;
      cand_cnt_q  <= cand_cnt_d;
    end
  end

  assign out_valid = (count_q != '0);
  assign full      = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign pop       = out_valid & bus_io.out_ready;
  assign push_req  = emit & ~(DROP_RESTS && (emit_note == NOTE_W'(REST_CODE)));
  assign push_ok   = push_req & (~full | pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_note_q[i] <= '0;
        mem_dur_q[i]  <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_note_q <= '0;
      last_dur_q  <= '0;
      drop_q      <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_note_q[wr_ptr_q] <= emit_note;
        mem_dur_q[wr_ptr_q]  <= emit_dur;
        wr_ptr_q             <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        last_note_q <= mem_note_q[rd_ptr_q];
        last_dur_q  <= mem_dur_q[rd_ptr_q];
        rd_ptr_q    <= rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (push_req && full && !pop) drop_q <= 1'b1;
    end
  end

  // Outputs keep showing the last popped entry while the FIFO is empty.
  assign bus_io.note_out  = out_valid ? mem_note_q[rd_ptr_q] : last_note_q;
  assign bus_io.duration  = out_valid ? mem_dur_q[rd_ptr_q] : last_dur_q;
  assign bus_io.out_valid = out_valid;
  assign bus_io.drop_err  = drop_q;
  assign bus_io.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_note_segmenter.sv
// Bench for note_segmenter: vector table, directed corner sequences and a
// randomized run against a segment-level reference model.
module tb_note_segmenter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] note_in = '0;
  logic       note_dec = 1'b0, flush = 1'b0, out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  note_segmenter_if #(.NOTE_W(8), .DUR_W(16)) b0 ();
  note_segmenter_if #(.NOTE_W(8), .DUR_W(16)) b1 ();
  note_segmenter_if #(.NOTE_W(8), .DUR_W(4))  b2 ();

  assign b0.note_in = note_in;  assign b0.note_dec = note_dec;
  assign b0.flush = flush;      assign b0.out_ready = out_ready;
  assign b1.note_in = note_in;  assign b1.note_dec = note_dec;
  assign b1.flush = flush;      assign b1.out_ready = out_ready;
  assign b2.note_in = note_in;  assign b2.note_dec = note_dec;
  assign b2.flush = flush;      assign b2.out_ready = out_ready;

  note_segmenter #(.NOTE_W(8), .DUR_W(16), .MIN_FRAMES(2), .REST_CODE(0), .DROP_RESTS(1'b0),
                   .FIFO_DEPTH(4)) u_main (.clk_i(clk), .rst_i(rst), .bus_io(b0));
  note_segmenter #(.NOTE_W(8), .DUR_W(16), .MIN_FRAMES(2), .REST_CODE(0), .DROP_RESTS(1'b1),
                   .FIFO_DEPTH(4)) u_rest (.clk_i(clk), .rst_i(rst), .bus_io(b1));
  note_segmenter #(.NOTE_W(8), .DUR_W(4), .MIN_FRAMES(2), .REST_CODE(0), .DROP_RESTS(1'b0),
                   .FIFO_DEPTH(4)) u_narrow (.clk_i(clk), .rst_i(rst), .bus_io(b2));

  always #5 clk = ~clk;

  bit collect = 1'b0;
  int got_n[$];
  int got_d[$];
  always @(negedge clk) begin
    if (collect && b0.out_valid && out_ready) begin
      got_n.push_back(int'(b0.note_out));
      got_d.push_back(int'(b0.duration));
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic frame(input int n);
    note_in = 8'(n);
    note_dec = 1'b1;
    @(posedge clk); #1;
    note_dec = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Segment-level reference: current run, pending candidate run, ideal FIFO.
  bit m_active;
  int m_cur, m_cnt, m_cand, m_ccnt;
  int qn[$];
  int qd[$];
  bit m_drop;

  task automatic model_step(input int n, input bit dec, input bit fl, input bit rdy);
    bit e = 1'b0;
    int en = 0, ed = 0;
    if (fl) begin
      if (m_active) begin
        e = 1'b1; en = m_cur; ed = m_cnt + m_ccnt;
        m_active = 1'b0; m_ccnt = 0;
      end
    end else if (dec) begin
      if (!m_active) begin
        m_active = 1'b1; m_cur = n; m_cnt = 1; m_ccnt = 0;
      end else if (m_ccnt == 0) begin
        if (n == m_cur) m_cnt++;
        else begin m_cand = n; m_ccnt = 1; end
      end else if (n == m_cand) begin
        m_ccnt++;
        if (m_ccnt == 2) begin
          e = 1'b1; en = m_cur; ed = m_cnt;
          m_cur = m_cand; m_cnt = 2; m_ccnt = 0;
        end
      end else if (n == m_cur) begin
        m_cnt += m_ccnt + 1; m_ccnt = 0;
      end else begin
        m_cnt += m_ccnt; m_cand = n; m_ccnt = 1;
      end
    end
    if (rdy && qn.size() > 0) begin
      void'(qn.pop_front()); void'(qd.pop_front());
    end
    if (e) begin
      if (qn.size() < 4) begin qn.push_back(en); qd.push_back(ed); end
      else m_drop = 1'b1;
    end
  endtask

  typedef struct packed {
    int n;     // number of frames
    int fr;    // frame codes, one hex digit each, first frame most significant
    int nseg;
    int n0; int d0; int n1; int d1;
  } vec_t;
  vec_t vecs[9];

  initial begin
    int bias;
    vecs[0] = '{6, 'h555777, 2, 5, 3, 7, 3};
    vecs[1] = '{5, 'h55955,  1, 5, 5, 0, 0};
    vecs[2] = '{6, 'h559333, 2, 5, 3, 3, 3};
    vecs[3] = '{3, 'h446,    1, 4, 3, 0, 0};
    vecs[4] = '{4, 'h4646,   1, 4, 4, 0, 0};
    vecs[5] = '{1, 'h8,      1, 8, 1, 0, 0};
    vecs[6] = '{5, 'h00044,  2, 0, 3, 4, 2};
    vecs[7] = '{6, 'h565656, 1, 5, 6, 0, 0};
    vecs[8] = '{4, 'h1122,   2, 1, 2, 2, 2};

    #12 rst = 1'b0;
    #1;
    check("reset_valid", b0.out_valid, 0);
    check("reset_note", b0.note_out, 0);
    check("reset_dur", b0.duration, 0);
    check("reset_drop", b0.drop_err, 0);
    check("reset_busy", b0.busy, 0);

    for (int v = 0; v < 9; v++) begin
      do_reset();
      out_ready = 1'b1;
      got_n.delete(); got_d.delete();
      collect = 1'b1;
      for (int i = 0; i < vecs[v].n; i++)
        frame((vecs[v].fr >> (4 * (vecs[v].n - 1 - i))) & 'hF);
      do_flush();
      idle(3);
      collect = 1'b0;
      check($sformatf("vec%0d_count", v), got_n.size(), vecs[v].nseg);
      if (got_n.size() > 0) begin
        check($sformatf("vec%0d_note0", v), got_n[0], vecs[v].n0);
        check($sformatf("vec%0d_dur0", v), got_d[0], vecs[v].d0);
      end
      if (got_n.size() > 1) begin
        check($sformatf("vec%0d_note1", v), got_n[1], vecs[v].n1);
        check($sformatf("vec%0d_dur1", v), got_d[1], vecs[v].d1);
      end
    end

    // One-cycle latency from the deciding strobe and from flush.
    do_reset();
    out_ready = 1'b1;
    frame(5); frame(5); frame(5); frame(7);
    check("lat_pre_valid", b0.out_valid, 0);
    check("lat_busy", b0.busy, 1);
    frame(7);
    check("lat_dec_valid", b0.out_valid, 1);
    check("lat_dec_note", b0.note_out, 5);
    check("lat_dec_dur", b0.duration, 3);
    frame(7);
    check("lat_popped", b0.out_valid, 0);
    do_flush();
    check("lat_fl_valid", b0.out_valid, 1);
    check("lat_fl_note", b0.note_out, 7);
    check("lat_fl_dur", b0.duration, 3);

    // Backpressure: five one-frame segments into a four-entry FIFO.
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin frame(k); do_flush(); end
    check("bp_valid", b0.out_valid, 1);
    check("bp_drop", b0.drop_err, 1);
    check("bp_head", b0.note_out, 1);
    got_n.delete(); got_d.delete();
    collect = 1'b1; out_ready = 1'b1;
    idle(8);
    collect = 1'b0; out_ready = 1'b0;
    check("bp_drain_count", got_n.size(), 4);
    for (int j = 0; j < 4 && j < got_n.size(); j++)
      check($sformatf("bp_order%0d", j), got_n[j], j + 1);
    check("bp_hold_valid", b0.out_valid, 0);
    check("bp_hold_note", b0.note_out, 4);
    check("bp_drop_sticky", b0.drop_err, 1);

    // Push onto a full FIFO in the same cycle as a pop.
    do_reset();
    for (int k = 1; k <= 4; k++) begin frame(k); do_flush(); end
    frame(5);
    got_n.delete(); got_d.delete();
    collect = 1'b1; out_ready = 1'b1;
    do_flush();
    idle(6);
    collect = 1'b0; out_ready = 1'b0;
    check("pp_drop", b0.drop_err, 0);
    check("pp_count", got_n.size(), 5);
    if (got_n.size() == 5) check("pp_last", got_n[4], 5);

    // Rest suppression.
    do_reset();
    frame(0); frame(0); frame(0); frame(4); frame(4);
    do_flush();
    check("rest_valid", b1.out_valid, 1);
    check("rest_note", b1.note_out, 4);
    check("rest_dur", b1.duration, 2);
    check("rest_drop", b1.drop_err, 0);
    check("rest_keep_note", b0.note_out, 0);
    check("rest_keep_dur", b0.duration, 3);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("rest_only_one", b1.out_valid, 0);

    // Duration saturation with a 4-bit counter.
    do_reset();
    repeat (20) frame(6);
    do_flush();
    check("sat_valid", b2.out_valid, 1);
    check("sat_note", b2.note_out, 6);
    check("sat_dur", b2.duration, 15);
    check("sat_wide_dur", b0.duration, 20);

    // Asynchronous reset while a candidate is pending.
    do_reset();
    frame(3); do_flush();
    frame(5); frame(5); frame(9);
    check("arst_pre_busy", b0.busy, 1);
    check("arst_pre_valid", b0.out_valid, 1);
    rst = 1'b1;
    #1;
    check("arst_valid", b0.out_valid, 0);
    check("arst_note", b0.note_out, 0);
    check("arst_dur", b0.duration, 0);
    check("arst_busy", b0.busy, 0);
    check("arst_drop", b0.drop_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    got_n.delete(); got_d.delete();
    collect = 1'b1; out_ready = 1'b1;
    frame(7); frame(7); do_flush();
    idle(3);
    collect = 1'b0;
    check("arst_fresh_count", got_n.size(), 1);
    if (got_n.size() > 0) begin
      check("arst_fresh_note", got_n[0], 7);
      check("arst_fresh_dur", got_d[0], 2);
    end

    // Randomized run against the reference model.
    do_reset();
    m_active = 1'b0; m_ccnt = 0; m_cnt = 0; m_cur = 0; m_cand = 0; m_drop = 1'b0;
    qn.delete(); qd.delete();
    bias = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 64 == 0) bias = int'($urandom_range(0, 2));
      note_dec  = ($urandom_range(0, 9) < 6);
      note_in   = 8'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 39) == 0);
      out_ready = (bias == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 8);
      @(posedge clk);
      model_step(int'(note_in), note_dec, flush, out_ready);
      #1;
      check("rnd_valid", b0.out_valid, qn.size() != 0);
      if (qn.size() != 0) begin
        check("rnd_note", b0.note_out, qn[0]);
        check("rnd_dur", b0.duration, qd[0]);
      end
      check("rnd_drop", b0.drop_err, m_drop);
      check("rnd_busy", b0.busy, m_active);
    end
    note_dec = 1'b0; flush = 1'b0; out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_segmenter.md
Name: note_segmenter

Overview:
- Parametrised successor to the frame-based note duration tracker.
- Consumes one detected note code per FFT frame (strobe note_dec) and groups consecutive equal frames into (note, duration-in-frames) segments.
- Adds glitch rejection (minimum confirm frames), rest suppression, duration saturation, end-of-song flush, and an output FIFO with a valid/ready handshake.
- Sits between the peak-magnitude note decoder and the transcription/MCU interface.

Parameters:
NOTE_W, 8, width of note code
DUR_W, 16, width of duration counter (frames)
MIN_FRAMES, 2, consecutive frames a differing note must persist before it is accepted (>=1; 1 = immediate switch)
REST_CODE, 0, note code meaning silence
DROP_RESTS, 0, 1 = segments whose note equals REST_CODE are not pushed to FIFO
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
note_in  in  NOTE_W  note code for current frame, valid when note_dec=1
note_dec  in  1  one-cycle frame strobe
flush  in  1  one-cycle pulse: close and emit current segment
note_out  out  NOTE_W  FIFO head note
duration  out  DUR_W  FIFO head duration (frames)
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head when out_valid&out_ready
drop_err  out  1  sticky: a segment was lost to a full FIFO
busy  out  1  state != IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, cur_note=0, cur_cnt=0, cand_note=0, cand_cnt=0, FIFO empty, note_out=0, duration=0, out_valid=0, drop_err=0, busy=0.
- All counter adds saturate at 2^DUR_W-1; no wrap.
- States:
  - IDLE: note_dec → cur_note=note_in, cur_cnt=1, go to TRACK.
  - TRACK:
    - note_dec with note_in==cur_note → cur_cnt+1.
    - note_dec with differing note, MIN_FRAMES==1 → emit (cur_note, cur_cnt); cur_note=note_in, cur_cnt=1.
    - note_dec with differing note, MIN_FRAMES>1 → cand_note=note_in, cand_cnt=1, go to CAND.
  - CAND:
    - note_dec with note_in==cand_note → cand_cnt+1; if cand_cnt+1==MIN_FRAMES: emit (cur_note, cur_cnt), cur_note=cand_note, cur_cnt=MIN_FRAMES, go to TRACK.
    - note_dec with note_in==cur_note → glitch absorbed: cur_cnt += cand_cnt+1, go to TRACK.
    - note_dec with a third note → cur_cnt += cand_cnt, cand_note=note_in, cand_cnt=1, stay in CAND.
- Frame accounting: the sum of emitted durations always equals the number of note_dec strobes, except under saturation.
- Flush:
  - In TRACK/CAND: cur_cnt += cand_cnt (pending candidate frames credited to current), emit, go to IDLE.
  - In IDLE: no effect.
  - Flush has priority: a note_dec in the same cycle is ignored (not counted).
- Emit:
  - Pushes into the FIFO on the deciding clock edge; the entry is visible on note_out/duration with out_valid=1 on the next cycle (1-cycle latency from the deciding strobe).
  - With DROP_RESTS=1 and note==REST_CODE, the segment is discarded silently and drop_err is not set.
- FIFO:
  - Pop when out_valid&out_ready.
  - Push while full is accepted only if a pop occurs in the same cycle; otherwise the segment is dropped and drop_err is set (sticky until reset).
  - Push and pop in the same cycle on an empty FIFO: the new entry appears next cycle; no bypass.
  - note_out/duration hold their last value when empty.
- Reset mid-segment discards all state; no emission.

Test Plan:
- MIN_FRAMES=2, out_ready=1; frames 5,5,5,7,7,7 then flush → outputs (5,3) then (7,3); each out_valid rises 1 cycle after its deciding strobe/flush.
- Glitch: frames 5,5,9,5,5, flush → single (5,5); no 9 segment.
- Third note in CAND: frames 5,5,9,3,3,3, flush → (5,3) then (3,3) (9 frame credited to 5).
- DROP_RESTS=1: frames 0,0,0,4,4, flush → only (4,2); drop_err=0.
- Backpressure, FIFO_DEPTH=4, out_ready=0: 5 segments emitted → first 4 retained in order, drop_err=1; releasing out_ready drains exactly 4 entries; push on a full FIFO with a simultaneous pop is not dropped.
- DUR_W=4: 20 frames of note 6, flush → (6,15). Async reset asserted mid-CAND → all outputs 0 immediately, out_valid=0, next frame starts a fresh segment.
